// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and types for the up/down counter
package counter_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 4;

  typedef enum logic {
    MODE_DOWN = 1'b0,
    MODE_UP   = 1'b1
  } count_mode_e;

endpackage

// File: rtl/intf.sv
// rtl/intf.sv - signal bundle for driving and observing the up/down counter
interface intf
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input logic clk
);

  // rst is active-low: 0 holds the counter cleared
  logic             rst;
  logic             mod;
  logic [WIDTH-1:0] count;

endinterface

// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - free-running wrap-around up/down counter
module up_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mod,
  output logic [WIDTH-1:0] count
);

  // Modular wrap falls out of the fixed register width; no saturation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (count_mode_e'(mod) == MODE_UP) begin
      count <= count + 1'b1;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_up_down_counter.sv
// tb/tb_up_down_counter.sv - directed and random checks of up_down_counter
module tb_up_down_counter;

  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             mod;
  logic [WIDTH-1:0] count;

  int errors;
  int checks;
  int exp_cnt;

  up_down_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .mod   (mod),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // advance one rising edge, then sample just after it
  task automatic tick_check(input string tag, input int want);
    @(posedge clk);
    #1;
    check(tag, int'(count), want);
  endtask

  // drop reset between edges and confirm the clear needs no clock
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_immediate"}, int'(count), 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    mod    = 1'b1;

    #3;
    check("reset_initial", int'(count), 0);
    tick_check("reset_held_1", 0);
    tick_check("reset_held_2", 0);

    // release between edges; release alone must not move count
    rst = 1'b1;
    #2;
    check("release_no_change", int'(count), 0);

    // up count with wrap 15 -> 0 -> 1
    mod = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick_check($sformatf("up_%0d", i), i % 16);
    end

    // count is 1 here: async clear, held while low
    async_reset("reset_clear");
    tick_check("reset_clear_held", 0);
    tick_check("reset_clear_held2", 0);

    // down count from 0 wraps to 15
    rst = 1'b1;
    mod = 1'b0;
    tick_check("down_1", 15);
    tick_check("down_2", 14);
    tick_check("down_3", 13);

    // direction switch: 5 up, 2 down
    async_reset("switch_reset");
    rst = 1'b1;
    mod = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick_check($sformatf("switch_up_%0d", i), i);
    end
    mod = 1'b0;
    tick_check("switch_down_1", 4);
    tick_check("switch_down_2", 3);

    // mid-run reset at 9, resume from 0
    async_reset("midrun_pre");
    rst = 1'b1;
    mod = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick_check($sformatf("midrun_up_%0d", i), i);
    end
    async_reset("midrun");
    rst = 1'b1;
    mod = 1'b1;
    tick_check("midrun_resume", 1);

    // random direction against a modular model
    exp_cnt = 1;
    for (int i = 0; i < 100; i++) begin
      mod = 1'($urandom_range(0, 1));
      exp_cnt = mod ? ((exp_cnt + 1) & MASK) : ((exp_cnt - 1) & MASK);
      tick_check($sformatf("rand_%0d", i), exp_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
